// File: rtl/genie_merge_pkg.sv
// Shared types and pointer helpers for the genie_merge_rr merge node.
package genie_merge_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  // Pointer width never collapses to zero bits, even for a single stream.
  function automatic int ptr_w(input int ni);
    return (ni > 1) ? $clog2(ni) : 1;
  endfunction

  // Wrapping increment with an explicit compare, so non-power-of-2 NI wraps correctly.
  function automatic int next_ptr(input int p, input int ni);
    return (p == ni - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/genie_rr_arb.sv
// Combinational round-robin arbiter: masked double priority encoder starting at i_ptr.
module genie_rr_arb
  import genie_merge_pkg::*;
#(
  parameter  int NI = 2,
  localparam int PW = ptr_w(NI)
) (
  input  logic [NI-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [NI-1:0] o_gnt,
  output logic [PW-1:0] o_gnt_idx,
  output logic          o_any
);

  logic [NI-1:0] w_hi;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    w_hi = '0;
    for (int i = 0; i < NI; i++) w_hi[i] = i_req[i] && (i >= int'(i_ptr));
  end

  // Lowest request overall, then overridden by the lowest request at or above the pointer.
  always_comb begin
    o_gnt_idx = i_ptr;
    o_any     = |i_req;
    for (int i = NI - 1; i >= 0; i--) if (i_req[i]) o_gnt_idx = PW'(i);
    for (int i = NI - 1; i >= 0; i--) if (w_hi[i])  o_gnt_idx = PW'(i);
    o_gnt = '0;
    for (int i = 0; i < NI; i++) o_gnt[i] = o_any && (PW'(i) == o_gnt_idx);
  end

endmodule

// File: rtl/genie_merge_rr.sv
// N-to-1 round-robin packet merge with grant held until end-of-packet.
// Optional GENIE_MERGE_OREG_EN adds a 2-entry skid buffer on the merged output.
module genie_merge_rr
  import genie_merge_pkg::*;
#(
  parameter  int NI = 2,
  parameter  int WD = 8,
  parameter  int WF = 4,
  localparam int PW = ptr_w(NI)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WD-1:0] i_data,
  input  logic [NI*WF-1:0] i_field,
  input  logic [NI-1:0]    i_eop,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WD-1:0]    o_data,
  output logic [WF-1:0]    o_field,
  output logic             o_eop,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PW-1:0]    o_owner
);

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   r_owner;

  logic [NI-1:0]   w_arb_gnt;
  logic [PW-1:0]   w_arb_idx;
  logic            w_arb_any;
  logic [NI-1:0]   w_onehot;
  logic [WD-1:0]   w_sel_data;
  logic [WF-1:0]   w_sel_field;
  logic            w_sel_eop;
  logic            w_sel_valid;
  logic            w_up_ready;
  logic            w_xfer;

  genie_rr_arb #(.NI(NI)) u_arb (
    .i_req     (i_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx),
    .o_any     (w_arb_any)
  );

  always_comb begin
    w_sel_data  = '0;
    w_sel_field = '0;
    w_sel_eop   = 1'b0;
    w_sel_valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      w_onehot[k] = (r_state == BUSY) ? (PW'(k) == r_owner) : w_arb_gnt[k];
      if (w_onehot[k]) begin
        w_sel_data  = i_data[WD*k +: WD];
        w_sel_field = i_field[WF*k +: WF];
        w_sel_eop   = i_eop[k];
        w_sel_valid = i_valid[k];
      end
    end
  end

  assign o_owner = (r_state == BUSY) ? r_owner : w_arb_idx;
  assign o_ready = w_onehot & {NI{w_up_ready}};
  assign w_xfer  = w_sel_valid && w_up_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_arb_any) begin
          if (w_xfer && w_sel_eop) begin
            r_ptr <= PW'(next_ptr(int'(w_arb_idx), NI));
          end else begin
            r_state <= BUSY;
            r_owner <= w_arb_idx;
          end
        end
        BUSY: if (w_xfer && w_sel_eop) begin
          r_state <= IDLE;
          r_ptr   <= PW'(next_ptr(int'(r_owner), NI));
        end
      endcase
    end
  end

`ifdef GENIE_MERGE_OREG_EN
  typedef struct packed {
    logic [WD-1:0] data;
    logic [WF-1:0] field;
    logic          eop;
  } beat_t;

  beat_t       r_buf [2];
  logic [1:0]  r_cnt;
  logic        w_pop;
  beat_t       w_in;

  assign w_in       = '{data: w_sel_data, field: w_sel_field, eop: w_sel_eop};
  assign w_up_ready = (r_cnt != 2'd2);
  assign w_pop      = o_valid && i_ready;
  assign o_valid    = (r_cnt != 2'd0);
  assign o_data     = r_buf[0].data;
  assign o_field    = r_buf[0].field;
  assign o_eop      = r_buf[0].eop;

  always_ff @(posedge clk) begin
    if (reset)                 r_cnt <= 2'd0;
    else if (w_xfer && !w_pop) r_cnt <= r_cnt + 2'd1;
    else if (w_pop && !w_xfer) r_cnt <= r_cnt - 2'd1;
  end

  // NOTE: buffer storage is not reset; r_cnt alone marks which entries hold valid beats.
  always_ff @(posedge clk) begin
    if (w_xfer && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) r_buf[0] <= w_in;
    else if (w_pop)                                             r_buf[0] <= r_buf[1];
    if (w_xfer && r_cnt == 2'd1 && !w_pop)                      r_buf[1] <= w_in;
  end
`else
  assign w_up_ready = i_ready;
  assign o_valid    = w_sel_valid;
  assign o_data     = w_sel_data;
  assign o_field    = w_sel_field;
  assign o_eop      = w_sel_eop;
`endif

endmodule

// File: tb/tb_genie_merge_rr.sv
// Self-checking bench for genie_merge_rr (NI=3, combinational build): vector table,
// hand-written packet sequences and randomized traffic against a behavioural model.
module tb_genie_merge_rr;

  localparam int NI = 3;
  localparam int WD = 8;
  localparam int WF = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] i_data;
  logic [11:0] i_field;
  logic [2:0]  i_eop, i_valid, o_ready;
  logic        i_ready;
  logic [7:0]  o_data;
  logic [3:0]  o_field;
  logic        o_eop, o_valid;
  logic [1:0]  o_owner;

  int checks   = 0;
  int failures = 0;

  genie_merge_rr #(.NI(NI), .WD(WD), .WF(WF)) dut (
    .clk(clk), .reset(reset), .i_data(i_data), .i_field(i_field), .i_eop(i_eop),
    .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data), .o_field(o_field),
    .o_eop(o_eop), .o_valid(o_valid), .i_ready(i_ready), .o_owner(o_owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  eop;
    logic        ready;
    logic [23:0] data;
    logic [11:0] field;
    logic        exp_valid;
    logic [1:0]  exp_owner;
    logic [2:0]  exp_ordy;
    logic [7:0]  exp_data;
    logic [3:0]  exp_field;
    logic        exp_eop;
  } vec_t;

  vec_t vecs [14];

  // Behavioural model: packet lock flag, owner and rotation pointer as plain integers.
  bit m_busy;
  int m_owner, m_ptr, m_g;
  bit m_found;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] e, input logic r,
                       input logic [23:0] d, input logic [11:0] f);
    i_valid = v; i_eop = e; i_ready = r; i_data = d; i_field = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0, 24'h0, 12'h0);
    tick();
    reset = 1'b0;
  endtask

  task automatic model_outputs(output logic ev, output logic [1:0] eo, output logic [2:0] er);
    m_found = 1'b0;
    m_g     = m_ptr;
    if (m_busy) m_g = m_owner;
    else
      for (int off = 0; off < NI; off++)
        if (!m_found && i_valid[(m_ptr + off) % NI]) begin
          m_g = (m_ptr + off) % NI;
          m_found = 1'b1;
        end
    ev = m_busy ? i_valid[m_g] : m_found;
    eo = 2'(m_g);
    er = (m_busy || m_found) ? (3'(i_ready) << m_g) : 3'b000;
  endtask

  task automatic model_update(input logic ev);
    bit done;
    done = ev && i_ready && i_eop[m_g];
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_owner = 0;
    end else if (m_busy) begin
      if (done) begin m_busy = 0; m_ptr = (m_owner + 1) % NI; end
    end else if (m_found) begin
      if (done) m_ptr = (m_g + 1) % NI;
      else begin m_busy = 1; m_owner = m_g; end
    end
  endtask

  initial begin
    logic       ev, ee;
    logic [1:0] eo;
    logic [2:0] er, rv, re;
    logic [23:0] rd;
    logic [11:0] rf;

    vecs[0]  = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd0, 3'b001, 8'h10, 4'h0, 1'b1};
    vecs[1]  = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd1, 3'b010, 8'h11, 4'h1, 1'b1};
    vecs[2]  = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd2, 3'b100, 8'h12, 4'h2, 1'b1};
    vecs[3]  = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd0, 3'b001, 8'h10, 4'h0, 1'b1};
    vecs[4]  = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd1, 3'b010, 8'h11, 4'h1, 1'b1};
    vecs[5]  = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd2, 3'b100, 8'h12, 4'h2, 1'b1};
    vecs[6]  = '{3'b010, 3'b111, 1'b0, 24'h12A510, 12'h230, 1'b1, 2'd1, 3'b000, 8'hA5, 4'h3, 1'b1};
    vecs[7]  = '{3'b011, 3'b111, 1'b0, 24'h12A510, 12'h230, 1'b1, 2'd1, 3'b000, 8'hA5, 4'h3, 1'b1};
    vecs[8]  = '{3'b011, 3'b111, 1'b1, 24'h12A510, 12'h230, 1'b1, 2'd1, 3'b010, 8'hA5, 4'h3, 1'b1};
    vecs[9]  = '{3'b000, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b0, 2'd2, 3'b000, 8'h00, 4'h0, 1'b0};
    vecs[10] = '{3'b001, 3'b000, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd0, 3'b001, 8'h10, 4'h0, 1'b0};
    vecs[11] = '{3'b110, 3'b110, 1'b1, 24'h121110, 12'h210, 1'b0, 2'd0, 3'b001, 8'h00, 4'h0, 1'b0};
    vecs[12] = '{3'b111, 3'b001, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd0, 3'b001, 8'h10, 4'h0, 1'b1};
    vecs[13] = '{3'b111, 3'b111, 1'b1, 24'h121110, 12'h210, 1'b1, 2'd1, 3'b010, 8'h11, 4'h1, 1'b1};

    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0, 24'h0, 12'h0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_state", {o_valid, o_owner, o_ready}, {1'b0, 2'd0, 3'b000});

    // Rotation, stall hold, idle pointer, mid-packet valid drop.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].valid, vecs[i].eop, vecs[i].ready, vecs[i].data, vecs[i].field);
      #1;
      check($sformatf("vec%0d_ctl", i), {o_valid, o_owner, o_ready},
            {vecs[i].exp_valid, vecs[i].exp_owner, vecs[i].exp_ordy});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_dat", i), {o_data, o_field, o_eop},
              {vecs[i].exp_data, vecs[i].exp_field, vecs[i].exp_eop});
      tick();
    end

    // 4-beat packet from stream 0 while stream 1 waits.
    do_reset();
    for (int b = 0; b < 4; b++) begin
      drive(3'b011, {2'b01, b == 3}, 1'b1, {8'h00, 8'h77, 8'(8'h40 + b)}, 12'h010);
      #1;
      check($sformatf("lock_beat%0d", b), {o_owner, o_ready, o_data, o_eop},
            {2'd0, 3'b001, 8'(8'h40 + b), b == 3});
      tick();
    end
    drive(3'b011, 3'b011, 1'b1, 24'h007744, 12'h010);
    #1;
    check("lock_next_owner", {o_valid, o_owner, o_ready, o_data}, {1'b1, 2'd1, 3'b010, 8'h77});
    tick();

    // Owner drops valid for 3 cycles mid-packet; stream 1 must not interleave.
    do_reset();
    drive(3'b011, 3'b010, 1'b1, 24'h005501, 12'h0);
    #1;
    check("drop_first", {o_valid, o_owner, o_ready, o_data}, {1'b1, 2'd0, 3'b001, 8'h01});
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(3'b010, 3'b010, 1'b1, 24'h005500, 12'h0);
      #1;
      check($sformatf("drop_gap%0d", c), {o_valid, o_owner, o_ready}, {1'b0, 2'd0, 3'b001});
      tick();
    end
    drive(3'b011, 3'b011, 1'b1, 24'h005502, 12'h0);
    #1;
    check("drop_resume", {o_valid, o_owner, o_data, o_eop}, {1'b1, 2'd0, 8'h02, 1'b1});
    tick();
    drive(3'b010, 3'b010, 1'b1, 24'h005500, 12'h0);
    #1;
    check("drop_then_s1", {o_valid, o_owner, o_data}, {1'b1, 2'd1, 8'h55});
    tick();

    // Reset while stream 2 holds the lock.
    do_reset();
    drive(3'b100, 3'b000, 1'b1, 24'hC00000, 12'h0);
    tick();
    drive(3'b111, 3'b000, 1'b1, 24'hC0B0A0, 12'h0);
    #1;
    check("rst_busy_owner", {o_owner, o_ready}, {2'd2, 3'b100});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rst_abort_s0", {o_valid, o_owner, o_ready, o_data}, {1'b1, 2'd0, 3'b001, 8'hA0});
    tick();

    // Randomized traffic against the model.
    do_reset();
    m_busy = 0; m_ptr = 0; m_owner = 0;
    for (int c = 0; c < 400; c++) begin
      rv = 3'($urandom);
      re = 3'($urandom) & 3'($urandom);
      rd = 24'($urandom);
      rf = 12'($urandom);
      drive(rv, re, 1'($urandom_range(3) != 0), rd, rf);
      reset = ($urandom_range(63) == 0);
      #1;
      model_outputs(ev, eo, er);
      check($sformatf("rnd%0d_ctl", c), {o_valid, o_owner, o_ready}, {ev, eo, er});
      if (ev) begin
        ee = i_eop[m_g];
        check($sformatf("rnd%0d_dat", c), {o_data, o_field, o_eop},
              {i_data[8*m_g +: 8], i_field[4*m_g +: 4], ee});
      end
      model_update(ev);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
